pool_result_packer: RTL and testbench
=====================================

Name: pool_result_packer

Overview:
- Downstream neighbour of the pooling unit.
- Each accepted cycle takes the D-lane pooled vector plus a lane-select mask marking which lanes hold final window maxima. It compacts the selected lanes in lane order (lane 0 first) and packs them into dense D-lane beats.
- Beats are emitted over a valid/ready stream to the output memory writer.
- Removes the holes that strided pooling leaves across lanes.

Parameters:
- depth, 3, log2 of lane count
- D, 1<<depth, lanes per vector/beat
- W, 16, bits per lane word
- FIFO_AW, 2, log2 of output FIFO entries (4 beats)

Ports:
- CLK  in  1  clock, all logic rising-edge
- RSTn  in  1  synchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept input this cycle
- in_data  in  W*D  pooled lanes, lane i at [W*(i+1)-1 -: W]
- in_mask  in  D  bit i=1: lane i is a result to keep
- flush  in  1  single-cycle pulse; emit any partial beat
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  W*D  packed beat, lane 0 = oldest word
- out_count  out  depth+1  number of valid lanes in beat (1..D)
- busy  out  1  fill>0, FIFO non-empty, or flush pending

Behaviour:
- Reset (RSTn=0 at a CLK edge) clears fill pointer, staging register, FIFO pointers and state.
  - out_valid=0, out_data=0, out_count=0, busy=0, in_ready=0 during reset.
  - in_ready=1 from the first cycle after reset is released.
- Accept when in_valid&&in_ready. popcount(in_mask)=P, 0..D.
  - Selected words are appended at staging positions fill..fill+P-1.
  - Staging is 2D words wide; fill+P<2D always holds.
- If fill+P>=D:
  - Staging[0..D-1] is pushed to the FIFO with count=D.
  - Staging[D..] shifts down.
  - New fill = fill+P-D.
  - Otherwise fill += P.
  - At most one push per accepted vector.
- P=0 with in_valid: accepted, no state change.
- in_ready = (state==RUN) && FIFO has >=1 free entry, evaluated for the current cycle; no push-through when full.
- States:
  - RUN: normal accept.
  - FLUSH: pushing a partial beat.
- flush in RUN:
  - The same-cycle accepted input is merged first (its full beat, if any, is pushed).
  - The state then goes to FLUSH.
  - If the post-merge fill is 0, flush is a no-op and the state stays RUN.
- FLUSH:
  - in_ready=0.
  - When the FIFO has room, push staging[0..fill-1] with count=fill, unused lanes zeroed.
  - fill=0, then return to RUN. If the FIFO is full, wait in FLUSH.
- flush asserted while in FLUSH is ignored.
- FIFO: registered outputs.
  - A beat pushed at edge n is visible as out_valid after edge n (1-cycle latency).
  - A pop occurs on out_valid&&out_ready.
  - Simultaneous push and pop on a full FIFO is not allowed, because in_ready already gates on free space.
- out_data and out_count are held stable while out_valid && !out_ready.
- Reset mid-operation: all buffered partial and queued beats are discarded. No output is produced for them.

Optional Feature:
- Macro POOL_PACKER_STATS_EN.
- Defined:
  - Adds output port stat_beats (32 bits): increments on each output handshake, saturates at all-ones.
  - Adds output port stat_words (32 bits): adds out_count on each output handshake, wraps.
  - Both are cleared by reset.
- Undefined: ports and counters are absent, with no other change in behaviour.

Decomposition:
- Package pool_packer_pkg holds:
  - state enum (RUN, FLUSH)
  - popcount and compaction helper functions parameterised on D
  - COUNT_W = depth+1
- Sub-module pool_packer_fifo: synchronous FIFO, width W*D+COUNT_W, depth 2^FIFO_AW, with full/empty/free flags.
- Compaction, staging and the state machine stay in the top module.

Test Plan (D=8, W=16):
- Reset: hold RSTn=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, busy=0. in_ready=1 in the first cycle after release.
- Stride-2 packing: two vectors with lanes 0..7 = k, mask 8'h55, first k=0x10.. then k=0x20.. -> one beat in the following cycle, words 0x10,0x12,0x14,0x16,0x20,0x22,0x24,0x26, count=8.
- Carry-over: mask 8'hFF then mask 8'h0F then flush -> full beat of vector-1 lanes, then a partial beat with 4 words and count=4, upper lanes 0.
- Flush with merge: fill=6, accept mask 8'h0F with flush=1 -> full beat (6+2 words), then the next beat with count=2 holding the remaining 2 words. in_ready=0 for that FLUSH cycle.
- Backpressure: out_ready=0, push 5 full beats -> in_ready drops after 4 beats and out_data is stable. Releasing out_ready drains the beats in order with none lost.
- Reset mid-stream: fill=3 and 2 beats queued, pulse RSTn=0 -> out_valid=0 next cycle. Later beats contain only post-reset data.

Source files
------------

// File: rtl/pool_packer_pkg.sv
// pool_packer_pkg: shared geometry, FSM state type and lane compaction helpers for the pool result packer
package pool_packer_pkg;
  localparam int LANES_LOG2 = 3;
  localparam int LANES = 1 << LANES_LOG2;
  localparam int WORD_W = 16;
  localparam int FIFO_AW_DEF = 2;
  localparam int COUNT_W = LANES_LOG2 + 1;
  typedef enum logic {RUN, FLUSH} state_e;
  function automatic logic [COUNT_W-1:0] popcount(input logic [LANES-1:0] m);
    popcount = '0;
    for (int i = 0; i < LANES; i++) popcount = popcount + COUNT_W'(m[i]);
  endfunction
  // Selected lanes land in lane order starting at word 0; the rest stay zero.
  function automatic logic [WORD_W*LANES-1:0] compact(input logic [WORD_W*LANES-1:0] d, input logic [LANES-1:0] m);
    int k;
    compact = '0;
    k = 0;
    for (int i = 0; i < LANES; i++)
      if (m[i]) begin
        compact[WORD_W*k +: WORD_W] = d[WORD_W*i +: WORD_W];
        k = k + 1;
      end
  endfunction
endpackage

// File: rtl/pool_packer_fifo.sv
// pool_packer_fifo: synchronous beat FIFO; head entry reads straight from storage, zero when empty
module pool_packer_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          free_o
);
  logic [DW-1:0] mem_q [1<<AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(1 << AW);
  assign empty_o = cnt_q == '0;
  assign free_o = !full_o;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/pool_result_packer.sv
// pool_result_packer: compacts masked pooled lanes into dense beats on a valid/ready stream; POOL_PACKER_STATS_EN adds beat/word counters
module pool_result_packer import pool_packer_pkg::*; #(
  parameter int depth = LANES_LOG2,
  parameter int D = 1 << depth,
  parameter int W = WORD_W,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*D-1:0]     in_data,
  input  logic [D-1:0]       in_mask,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*D-1:0]     out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy
`ifdef POOL_PACKER_STATS_EN
  ,
  output logic [31:0]        stat_beats,
  output logic [31:0]        stat_words
`endif
);
  state_e state_q, state_d;
  logic [COUNT_W-1:0] fill_q, fill_d, fill_m, p, sum;
  logic [2*W*D-1:0] stage_q, stage_d, ext, merged;
  logic acc, full_push, flush_push, push, pop;
  logic fifo_full, fifo_empty, fifo_free;
  logic [W*D+COUNT_W-1:0] push_data, pop_data;
  always_comb begin
    acc = in_valid && in_ready;
    p = acc ? popcount(in_mask) : '0;
    sum = fill_q + p;
    ext = {{(W*D){1'b0}}, acc ? compact(in_data, in_mask) : {(W*D){1'b0}}};
    merged = stage_q | (ext << (W*fill_q));
    full_push = sum >= COUNT_W'(D);
    flush_push = state_q == FLUSH && !fifo_full;
    push = full_push || flush_push;
    push_data = full_push ? {COUNT_W'(D), merged[W*D-1:0]} : {fill_q, stage_q[W*D-1:0]};
    fill_m = full_push ? sum - COUNT_W'(D) : sum;
    fill_d = flush_push ? '0 : fill_m;
    stage_d = flush_push ? '0 : full_push ? merged >> (W*D) : merged;
  end
  always_ff @(posedge CLK)
    if (!RSTn) begin
      fill_q <= '0;
      stage_q <= '0;
    end else begin
      fill_q <= fill_d;
      stage_q <= stage_d;
    end
  always_ff @(posedge CLK)
    if (!RSTn) state_q <= RUN;
    else state_q <= state_d;
  // A flush that leaves nothing staged after the merge is a no-op.
  always_comb
    state_d = state_q == RUN ? ((flush && fill_m != '0) ? FLUSH : RUN) : (fifo_full ? FLUSH : RUN);
  always_comb begin
    in_ready = RSTn && state_q == RUN && fifo_free;
    busy = RSTn && (fill_q != '0 || !fifo_empty || state_q == FLUSH);
    out_valid = RSTn && !fifo_empty;
    {out_count, out_data} = RSTn ? pop_data : '0;
  end
  assign pop = out_valid && out_ready;
  pool_packer_fifo #(.DW(W*D+COUNT_W), .AW(FIFO_AW)) u_fifo (
    .clk_i(CLK),
    .rst_ni(RSTn),
    .push_i(push),
    .data_i(push_data),
    .pop_i(pop),
    .data_o(pop_data),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .free_o(fifo_free)
  );
`ifdef POOL_PACKER_STATS_EN
  logic [31:0] beats_q, words_q;
  always_ff @(posedge CLK)
    if (!RSTn) begin
      beats_q <= '0;
      words_q <= '0;
    end else if (pop) begin
      beats_q <= beats_q == '1 ? beats_q : beats_q + 32'd1;
      words_q <= words_q + 32'(out_count);
    end
  assign stat_beats = beats_q;
  assign stat_words = words_q;
`endif
endmodule

// File: tb/tb_pool_result_packer.sv
// tb_pool_result_packer: directed stimulus with a queued scoreboard checked by a decoupled output monitor
module tb_pool_result_packer;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [127:0] in_data = '0;
  logic [7:0] in_mask = '0;
  logic flush = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0] out_count;
  logic busy;
`ifdef POOL_PACKER_STATS_EN
  logic [31:0] stat_beats, stat_words;
`endif
  int checks = 0;
  int errs = 0;
  logic [131:0] sb [$];
  always #5 CLK = ~CLK;
  pool_result_packer dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mask(in_mask),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count),
    .busy(busy)
`ifdef POOL_PACKER_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_words(stat_words)
`endif
  );
  function automatic logic [127:0] vec(input logic [15:0] base);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = base + 16'(i);
    return v;
  endfunction
  function automatic logic [127:0] pk(input logic [15:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction
  task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic expect_beat(input logic [3:0] c, input logic [127:0] d);
    sb.push_back({c, d});
  endtask
  task automatic drive(input logic [127:0] d, input logic [7:0] m, input logic f);
    int n = 0;
    in_data = d;
    in_mask = m;
    in_valid = 1'b1;
    flush = f;
    while (!in_ready && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 132'(in_ready), 132'(1));
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask
  task automatic settle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("drain", 132'({busy, sb.size() != 0}), 132'(0));
  endtask
  initial begin
    fork
      forever begin
        @(negedge CLK);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_beat: got %h expected none", {out_count, out_data});
          end else chk("beat", {out_count, out_data}, sb.pop_front());
        end
      end
    join_none
    in_valid = 1'b1;
    in_mask = 8'hFF;
    in_data = vec(16'h0001);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 132'(out_valid), 132'(0));
    chk("rst_in_ready", 132'(in_ready), 132'(0));
    chk("rst_busy", 132'(busy), 132'(0));
    chk("rst_out_data", {out_count, out_data}, 132'(0));
    RSTn = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("release_in_ready", 132'(in_ready), 132'(1));
    chk("release_out_valid", 132'(out_valid), 132'(0));
    expect_beat(4'd8, pk(16'h10, 16'h12, 16'h14, 16'h16, 16'h20, 16'h22, 16'h24, 16'h26));
    drive(vec(16'h10), 8'h55, 1'b0);
    drive(vec(16'h20), 8'h55, 1'b0);
    chk("stride_latency", 132'(out_valid), 132'(1));
    settle();
    expect_beat(4'd8, vec(16'h30));
    expect_beat(4'd4, pk(16'h40, 16'h41, 16'h42, 16'h43, 16'h0, 16'h0, 16'h0, 16'h0));
    drive(vec(16'h30), 8'hFF, 1'b0);
    drive(vec(16'h40), 8'h0F, 1'b0);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    settle();
    expect_beat(4'd8, pk(16'h50, 16'h51, 16'h52, 16'h53, 16'h54, 16'h55, 16'h60, 16'h61));
    expect_beat(4'd2, pk(16'h62, 16'h63, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    drive(vec(16'h50), 8'h3F, 1'b0);
    drive(vec(16'h60), 8'h0F, 1'b1);
    chk("flush_in_ready", 132'(in_ready), 132'(0));
    settle();
    drive(vec(16'h70), 8'h00, 1'b0);
    chk("empty_mask_busy", 132'(busy), 132'(0));
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    chk("noop_flush_ready", {busy, in_ready, out_valid}, 132'(3'b010));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_beat(4'd8, vec(16'(16'hA00 + 16 * i)));
    for (int i = 0; i < 4; i++) drive(vec(16'(16'hA00 + 16 * i)), 8'hFF, 1'b0);
    chk("bp_in_ready", 132'(in_ready), 132'(0));
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_stable", {out_count, out_data}, {4'd8, vec(16'hA00)});
    chk("bp_valid", 132'(out_valid), 132'(1));
    out_ready = 1'b1;
    drive(vec(16'hA40), 8'hFF, 1'b0);
    settle();
    out_ready = 1'b0;
    drive(vec(16'hB00), 8'hFF, 1'b0);
    drive(vec(16'hB10), 8'hFF, 1'b0);
    drive(vec(16'hB20), 8'h07, 1'b0);
    chk("pre_rst_busy", 132'(busy), 132'(1));
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    #1;
    chk("midrst_out_valid", 132'(out_valid), 132'(0));
    chk("midrst_busy", 132'(busy), 132'(0));
    out_ready = 1'b1;
    expect_beat(4'd8, vec(16'hC00));
    drive(vec(16'hC00), 8'hFF, 1'b0);
    settle();
    repeat (5) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
